// File: rtl/mux_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mux_rr_arbiter_if
//  Brief    : Request/grant bundle between N requesters and the round-robin
//             mux arbiter. The master modport is the arbiter side (drives the
//             mux select and grant vector); the slave modport is the
//             requester side.
//  Revision : 1.0  initial release
// ============================================================================
interface mux_rr_arbiter_if #(
   parameter int N = 8
);
   localparam int M = $clog2(N);

   logic [N-1:0] req;
   logic [M-1:0] select;
   logic [N-1:0] grant;
   logic         grant_valid;
   logic         timeout;

   modport master (
      input  req,
      output select,
      output grant,
      output grant_valid,
      output timeout
   );

   modport slave (
      output req,
      input  select,
      input  grant,
      input  grant_valid,
      input  timeout
   );
endinterface
`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mux_rr_arbiter
//  Brief    : Round-robin arbiter owning the select port of an N:1 mux. A
//             grant is held for the whole transaction of its owner and the
//             select only moves when ownership changes. On release the next
//             owner is granted at the same edge (no idle bubble).
//             Optional macro MUX_ARB_TIMEOUT_EN adds a hold counter that
//             forces a release after MAX_HOLD cycles and pulses timeout.
//  Revision : 1.0  initial release
// ============================================================================
module mux_rr_arbiter #(
   parameter int N        = 8,
   parameter int MAX_HOLD = 16
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   mux_rr_arbiter_if.master  bus
);
   localparam int M = $clog2(N);

   // Reject unsupported configurations at elaboration time.
   if ((N < 2) || ((N & (N - 1)) != 0) || (MAX_HOLD < 1) || (MAX_HOLD > 255)) begin : g_bad_cfg
      $error("mux_rr_arbiter: N must be a power of two >= 2 and MAX_HOLD in 1..255");
   end

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t         r_state,   w_state_nxt;
   logic [N-1:0]   r_grant,   w_grant_nxt;
   logic [M-1:0]   r_select,  w_select_nxt;
   logic [M-1:0]   r_last,    w_last_nxt;
   logic           r_timeout, w_timeout_nxt;

   logic           w_owner_req;
   logic           w_force;
   logic [N-1:0]   w_cand;
   logic [M-1:0]   w_base;
   logic [M-1:0]   w_idx;
   logic [M-1:0]   w_win;
   logic           w_found;

   // The owner is still requesting when its grant bit meets its req bit.
   assign w_owner_req = |(bus.req & r_grant);

`ifdef MUX_ARB_TIMEOUT_EN
   localparam int HW = $clog2(MAX_HOLD + 1);
   logic [HW-1:0]  r_cnt, w_cnt_nxt;

   // Forced release happens on the edge that would complete MAX_HOLD cycles
   // of ownership, so a grant never lasts longer than MAX_HOLD cycles.
   assign w_force = (r_state == BUSY) && w_owner_req && (r_cnt == HW'(MAX_HOLD - 1));

   // Hold counter: cleared on every new grant, counts ownership cycles.
   always_comb begin
      w_cnt_nxt = r_cnt;
      if ((r_state == IDLE) || !w_owner_req || w_force) begin
         w_cnt_nxt = '0;
      end else begin
         w_cnt_nxt = r_cnt + 1'b1;
      end
   end

   // Hold counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_nxt;
      end
   end
`else
   assign w_force = 1'b0;
`endif

   // Candidates: on a forced release the current owner is excluded unless
   // it is the only requester, in which case it simply wins again.
   always_comb begin
      w_cand = bus.req;
      if (w_force && (|(bus.req & ~r_grant))) begin
         w_cand = bus.req & ~r_grant;
      end
   end

   // Round-robin search starting just after the base index; the base itself
   // is visited last so a lone re-requesting owner can still win.
   always_comb begin
      w_base  = (r_state == BUSY) ? r_select : r_last;
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = '0;
      for (int k = 1; k <= N; k++) begin
         w_idx = w_base + M'(k);
         if (!w_found && w_cand[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
      end
   end

   // Next-state and next-output decode.
   always_comb begin
      w_state_nxt   = r_state;
      w_grant_nxt   = r_grant;
      w_select_nxt  = r_select;
      w_last_nxt    = r_last;
      w_timeout_nxt = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_found) begin
               w_grant_nxt  = {{(N-1){1'b0}}, 1'b1} << w_win;
               w_select_nxt = w_win;
               w_state_nxt  = BUSY;
            end
         end
         BUSY: begin
            if (!w_owner_req || w_force) begin
               w_last_nxt    = r_select;
               w_timeout_nxt = w_force;
               if (w_found) begin
                  w_grant_nxt  = {{(N-1){1'b0}}, 1'b1} << w_win;
                  w_select_nxt = w_win;
               end else begin
                  // Select keeps the old owner so the mux path stays quiet.
                  w_grant_nxt = '0;
                  w_state_nxt = IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_grant_nxt = '0;
         end
      endcase
   end

   // State and registered outputs; last starts at N-1 so index 0 is first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_grant   <= '0;
         r_select  <= '0;
         r_last    <= M'(N - 1);
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_grant   <= w_grant_nxt;
         r_select  <= w_select_nxt;
         r_last    <= w_last_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   assign bus.grant       = r_grant;
   assign bus.select      = r_select;
   assign bus.grant_valid = |r_grant;
   assign bus.timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_rr_arbiter
//  Brief    : Directed self-checking bench for mux_rr_arbiter (N=8,
//             MAX_HOLD=4). Timeout scenarios are selected by
//             MUX_ARB_TIMEOUT_EN, matching the design build.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mux_rr_arbiter;
   logic clk;
   logic rst_n;
   int   n_run;
   int   n_fail;

   mux_rr_arbiter_if #(.N(8)) u_if ();

   mux_rr_arbiter #(.N(8), .MAX_HOLD(4)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges; inputs change and outputs are sampled 1ns later.
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      u_if.req = 8'h00;
      cyc(1);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      u_if.req = 8'h00;
      cyc(2);
      n_run++;
      if (u_if.grant !== 8'h00 || u_if.select !== 3'd0 || u_if.grant_valid !== 1'b0 || u_if.timeout !== 1'b0) begin
         $display("FAIL reset_init grant=%h sel=%0d gv=%b to=%b exp 00/0/0/0", u_if.grant, u_if.select, u_if.grant_valid, u_if.timeout);
         n_fail++;
      end
      rst_n    = 1'b1;
      u_if.req = 8'h20;
      cyc(1);
      n_run++;
      if (u_if.grant !== 8'h20 || u_if.select !== 3'd5) begin
         $display("FAIL reset_owner5 grant=%h sel=%0d exp 20/5", u_if.grant, u_if.select);
         n_fail++;
      end
      cyc(2);
      #2 rst_n = 1'b0;
      #1;
      n_run++;
      if (u_if.grant !== 8'h00 || u_if.select !== 3'd0 || u_if.grant_valid !== 1'b0) begin
         $display("FAIL reset_async grant=%h sel=%0d gv=%b exp 00/0/0", u_if.grant, u_if.select, u_if.grant_valid);
         n_fail++;
      end
      cyc(1);
      rst_n = 1'b1;
      n_run++;
      if (u_if.grant !== 8'h00) begin
         $display("FAIL reset_release_pre grant=%h exp 00", u_if.grant);
         n_fail++;
      end
      cyc(1);
      n_run++;
      if (u_if.grant !== 8'h20 || u_if.select !== 3'd5 || u_if.grant_valid !== 1'b1) begin
         $display("FAIL reset_regrant grant=%h sel=%0d gv=%b exp 20/5/1", u_if.grant, u_if.select, u_if.grant_valid);
         n_fail++;
      end
      u_if.req = 8'h00;
      cyc(1);
   endtask

   task automatic test_single();
      u_if.req = 8'h04;
      cyc(1);
      n_run++;
      if (u_if.grant !== 8'h04 || u_if.select !== 3'd2 || u_if.grant_valid !== 1'b1) begin
         $display("FAIL single_grant grant=%h sel=%0d gv=%b exp 04/2/1", u_if.grant, u_if.select, u_if.grant_valid);
         n_fail++;
      end
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         n_run++;
         if (u_if.grant !== 8'h04 || u_if.select !== 3'd2) begin
            $display("FAIL single_hold[%0d] grant=%h sel=%0d exp 04/2", i, u_if.grant, u_if.select);
            n_fail++;
         end
      end
      u_if.req = 8'h00;
      cyc(1);
      n_run++;
      if (u_if.grant !== 8'h00 || u_if.grant_valid !== 1'b0 || u_if.select !== 3'd2) begin
         $display("FAIL single_release grant=%h gv=%b sel=%0d exp 00/0/2", u_if.grant, u_if.grant_valid, u_if.select);
         n_fail++;
      end
      cyc(1);
      n_run++;
      if (u_if.grant !== 8'h00) begin
         $display("FAIL single_idle grant=%h exp 00", u_if.grant);
         n_fail++;
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_g;
      int         own;
      do_reset();
      u_if.req = 8'hFF;
      cyc(1);
      own = 0;
      for (int i = 0; i < 9; i++) begin
         exp_g = 8'h01 << own;
         n_run++;
         if (u_if.grant !== exp_g || u_if.select !== 3'(own) || u_if.grant_valid !== 1'b1) begin
            $display("FAIL rotate[%0d] grant=%h sel=%0d gv=%b exp %h/%0d/1", i, u_if.grant, u_if.select, u_if.grant_valid, exp_g, own);
            n_fail++;
         end
         cyc(2);
         u_if.req = 8'hFF & ~exp_g;
         cyc(1);
         u_if.req = 8'hFF;
         own = (own + 1) % 8;
      end
      n_run++;
      if (u_if.grant !== 8'h02) begin
         $display("FAIL rotate_end grant=%h exp 02", u_if.grant);
         n_fail++;
      end
      u_if.req = 8'h00;
      cyc(1);
   endtask

   task automatic test_wrap();
      do_reset();
      u_if.req = 8'h80;
      cyc(1);
      n_run++;
      if (u_if.grant !== 8'h80 || u_if.select !== 3'd7) begin
         $display("FAIL wrap_owner7 grant=%h sel=%0d exp 80/7", u_if.grant, u_if.select);
         n_fail++;
      end
      u_if.req = 8'h01;
      cyc(1);
      u_if.req = 8'h81;
      n_run++;
      if (u_if.grant !== 8'h01 || u_if.select !== 3'd0) begin
         $display("FAIL wrap_to0 grant=%h sel=%0d exp 01/0", u_if.grant, u_if.select);
         n_fail++;
      end
      cyc(2);
      n_run++;
      if (u_if.grant !== 8'h01) begin
         $display("FAIL wrap_hold0 grant=%h exp 01", u_if.grant);
         n_fail++;
      end
      u_if.req = 8'h80;
      cyc(1);
      u_if.req = 8'h81;
      n_run++;
      if (u_if.grant !== 8'h80 || u_if.select !== 3'd7) begin
         $display("FAIL fair_to7 grant=%h sel=%0d exp 80/7", u_if.grant, u_if.select);
         n_fail++;
      end
      cyc(1);
      n_run++;
      if (u_if.grant !== 8'h80) begin
         $display("FAIL fair_hold7 grant=%h exp 80", u_if.grant);
         n_fail++;
      end
      u_if.req = 8'h00;
      cyc(1);
      u_if.req = 8'h81;
      cyc(1);
      n_run++;
      if (u_if.grant !== 8'h01) begin
         $display("FAIL idle_from_last7 grant=%h exp 01", u_if.grant);
         n_fail++;
      end
      u_if.req = 8'h00;
      cyc(1);
   endtask

   task automatic test_ignored();
      u_if.req = 8'h08;
      cyc(1);
      for (int i = 0; i < 8; i++) begin
         u_if.req = (i % 2 == 0) ? 8'h4A : 8'h08;
         n_run++;
         if (u_if.grant !== 8'h08 || u_if.select !== 3'd3) begin
            $display("FAIL ignored[%0d] grant=%h sel=%0d exp 08/3", i, u_if.grant, u_if.select);
            n_fail++;
         end
         cyc(1);
      end
      u_if.req = 8'h42;
      cyc(1);
      n_run++;
      if (u_if.grant !== 8'h40 || u_if.select !== 3'd6 || u_if.grant_valid !== 1'b1) begin
         $display("FAIL ignored_next grant=%h sel=%0d gv=%b exp 40/6/1", u_if.grant, u_if.select, u_if.grant_valid);
         n_fail++;
      end
      u_if.req = 8'h00;
      cyc(1);
   endtask

`ifdef MUX_ARB_TIMEOUT_EN
   task automatic test_timeout();
      do_reset();
      u_if.req = 8'h03;
      cyc(1);
      for (int i = 0; i < 4; i++) begin
         n_run++;
         if (u_if.grant !== 8'h01 || u_if.timeout !== 1'b0) begin
            $display("FAIL to_hold0[%0d] grant=%h to=%b exp 01/0", i, u_if.grant, u_if.timeout);
            n_fail++;
         end
         if (i < 3) cyc(1);
      end
      cyc(1);
      n_run++;
      if (u_if.timeout !== 1'b1 || u_if.grant !== 8'h02) begin
         $display("FAIL to_force grant=%h to=%b exp 02/1", u_if.grant, u_if.timeout);
         n_fail++;
      end
      u_if.req = 8'h01;
      cyc(1);
      n_run++;
      if (u_if.timeout !== 1'b0 || u_if.grant !== 8'h01) begin
         $display("FAIL to_normal_rel grant=%h to=%b exp 01/0", u_if.grant, u_if.timeout);
         n_fail++;
      end
      cyc(3);
      n_run++;
      if (u_if.timeout !== 1'b0 || u_if.grant !== 8'h01) begin
         $display("FAIL to_solo_pre grant=%h to=%b exp 01/0", u_if.grant, u_if.timeout);
         n_fail++;
      end
      cyc(1);
      n_run++;
      if (u_if.timeout !== 1'b1 || u_if.grant !== 8'h01) begin
         $display("FAIL to_solo grant=%h to=%b exp 01/1", u_if.grant, u_if.timeout);
         n_fail++;
      end
      cyc(1);
      n_run++;
      if (u_if.timeout !== 1'b0 || u_if.grant !== 8'h01) begin
         $display("FAIL to_pulse_end grant=%h to=%b exp 01/0", u_if.grant, u_if.timeout);
         n_fail++;
      end
      u_if.req = 8'h00;
      cyc(1);
   endtask
`else
   task automatic test_timeout();
      do_reset();
      u_if.req = 8'h03;
      cyc(1);
      for (int i = 0; i < 20; i++) begin
         n_run++;
         if (u_if.grant !== 8'h01 || u_if.timeout !== 1'b0) begin
            $display("FAIL no_timeout[%0d] grant=%h to=%b exp 01/0", i, u_if.grant, u_if.timeout);
            n_fail++;
         end
         cyc(1);
      end
      u_if.req = 8'h00;
      cyc(1);
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog run exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      n_run    = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      u_if.req = 8'h00;
      test_reset();
      test_single();
      test_back_to_back();
      test_wrap();
      test_ignored();
      test_timeout();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares one N:1 selection multiplexer among N requesters.
- Drives the mux select port directly and holds a grant for the whole transaction of the winning requester.
- Sits beside the mux: requesters raise req, the arbiter picks one owner, and the select stays stable until the owner releases.

Parameters:
- N, 8, number of requesters = mux inputs; power of two, N >= 2.
- m, $clog2(N), select width; derived, never overridden.
- MAX_HOLD, 16, maximum grant length in cycles; used only with MUX_ARB_TIMEOUT_EN; 1..255.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  per-requester request level; bit i high = requester i wants the mux.
- select  output  m  mux select = binary index of current owner.
- grant  output  N  one-hot owner vector; all-zero when idle.
- grant_valid  output  1  high while any grant is held (= |grant).
- timeout  output  1  one-cycle pulse on a forced release; constant 0 without the macro.

Behaviour:
- Reset (async, rst_n low):
  - grant = 0, grant_valid = 0, select = 0, timeout = 0.
  - state = IDLE, last pointer = N-1 (first search starts at index 0), hold counter = 0.
  - Reset may assert in any state; outputs clear immediately, no edge needed.
- States: IDLE, BUSY. All outputs are registered.
- Search rule: scan indices last+1, last+2, ... mod N; the first index with req set wins.
- IDLE:
  - If |req at a rising edge: winner w per search rule; grant = 1<<w, select = w, grant_valid = 1, go to BUSY.
  - Latency: req seen at edge k gives grant valid after edge k (one cycle).
  - If req == 0: stay IDLE, outputs 0.
- BUSY, owner o:
  - Grant and select are held while req[o] = 1.
  - Changes on other req bits are ignored until release.
- Release: at an edge where req[o] = 0:
  - last <= o.
  - If other requests are pending: search from o+1 and grant the winner at the same edge (back-to-back, no idle cycle). A winner index that wraps past N-1 restarts at 0.
  - Else: grant = 0, grant_valid = 0, select holds its last value, go to IDLE.
- A requester dropping req and re-raising it in the same cycle window is treated as a fresh request; it gets no priority over others.
- select changes only at grant changes, so the mux output is glitch-stable for the whole transaction.

Optional Feature:
- Macro: MUX_ARB_TIMEOUT_EN.
- Defined:
  - A hold counter (width $clog2(MAX_HOLD+1)) clears on each new grant and increments each BUSY cycle.
  - When the counter reaches MAX_HOLD and req[o] is still high, the arbiter forces a release: timeout = 1 for one cycle, last <= o, and it re-arbitrates at that edge among requesters other than o.
  - If o is the only requester, o is re-granted, the counter clears, and timeout still pulses.
  - Normal release before MAX_HOLD produces no pulse.
- Not defined: no counter logic; the grant is held indefinitely until req[o] drops; timeout tied 0.

Test Plan:
- Reset: rst_n low mid-BUSY with N=8, owner 5 -> grant = 0, select = 0, grant_valid = 0 immediately; after release, req=8'h20 gives grant 8'h20 one cycle later.
- Single request: req = 8'h04 from IDLE -> next cycle grant = 8'h04, select = 2; hold req 10 cycles -> select stays 2; drop req -> next cycle grant = 0, go to IDLE.
- Rotation: req = 8'hFF held, each owner drops req for one cycle after 3 cycles and then re-raises it -> grants visit 0, 1, 2, ... 7, 0 in order, back-to-back with no idle cycle.
- Wrap-around and fairness: owner 7 releases with req = 8'h81 -> grant 0, not 7; then owner 0 releases with req = 8'h81 -> grant 7.
- Ignored contenders: owner 3 holding, req bits 1 and 6 toggle every cycle -> grant stays 8'h08 and select stays 3 throughout.
- Timeout (macro defined, MAX_HOLD=4):
  - req = 8'h03, owner 0 never drops -> after 4 BUSY cycles timeout pulses and grant = 8'h02.
  - With req = 8'h01 only -> timeout pulses and grant stays 8'h01.
